// File: rtl/sdinit_pkg.sv
// Shared types and constants for the SD-card initialization sequencer.
package sdinit_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_PWRUP,
    ST_CMD0,
    ST_CMD8,
    ST_CMD55,
    ST_ACMD41,
    ST_CMD2,
    ST_CMD3,
    ST_DONE,
    ST_ERR
  } sd_state_e;

  localparam logic [5:0] CMD0_IDX   = 6'd0;
  localparam logic [5:0] CMD2_IDX   = 6'd2;
  localparam logic [5:0] CMD3_IDX   = 6'd3;
  localparam logic [5:0] CMD8_IDX   = 6'd8;
  localparam logic [5:0] CMD55_IDX  = 6'd55;
  localparam logic [5:0] ACMD41_IDX = 6'd41;

  localparam logic [2:0] ERR_NONE   = 3'd0;
  localparam logic [2:0] ERR_ECHO   = 3'd1;
  localparam logic [2:0] ERR_A41TO  = 3'd2;
  localparam logic [2:0] ERR_NORSP  = 3'd3;

  localparam logic [31:0] ACMD41_ARG_BASE = 32'h00FF_8000;
  localparam logic [31:0] ACMD41_HCS_BIT  = 32'h4000_0000;

  // Response byte pointers as delivered by the CMD engine
  localparam logic [2:0] PTR_B1 = 3'd1;
  localparam logic [2:0] PTR_B2 = 3'd2;
  localparam logic [2:0] PTR_B3 = 3'd3;
  localparam logic [2:0] PTR_B4 = 3'd4;

  typedef struct packed {
    logic [5:0]  idx;
    logic [31:0] arg;
  } sd_cmd_t;

  function automatic logic is_cmd_state(input sd_state_e s);
    return (s == ST_CMD0) || (s == ST_CMD8) || (s == ST_CMD55) ||
           (s == ST_ACMD41) || (s == ST_CMD2) || (s == ST_CMD3);
  endfunction

  // Index and argument issued on entry to each command state
  function automatic sd_cmd_t cmd_for_state(input sd_state_e s, input logic [15:0] rca,
                                            input logic hcs, input logic [3:0] vhs,
                                            input logic [7:0] pat);
    sd_cmd_t c;
    c = '{idx: CMD0_IDX, arg: 32'h0};
    case (s)
      ST_CMD8:   c = '{idx: CMD8_IDX, arg: {20'h0, vhs, pat}};
      ST_CMD55:  c = '{idx: CMD55_IDX, arg: {rca, 16'h0}};
      ST_ACMD41: c = '{idx: ACMD41_IDX, arg: ACMD41_ARG_BASE | (hcs ? ACMD41_HCS_BIT : 32'h0)};
      ST_CMD2:   c = '{idx: CMD2_IDX, arg: 32'h0};
      ST_CMD3:   c = '{idx: CMD3_IDX, arg: 32'h0};
      default:   c = '{idx: CMD0_IDX, arg: 32'h0};
    endcase
    return c;
  endfunction

endpackage

// File: rtl/sd_rsp_capt.sv
// Pointer-qualified capture of the R7 echo, OCR status byte and RCA.
// SDINIT_HCS_EN adds capture of the OCR CCS bit.
module sd_rsp_capt
  import sdinit_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clr,
  input  logic        rsp_vld,
  input  logic [2:0]  rsp_ptr,
  input  logic [7:0]  rsp_byte,
  input  logic        we_r7,
  input  logic        we_ocr,
  input  logic        we_rca,
  output logic [3:0]  vhs_c,
  output logic [7:0]  pat_c,
  output logic        ocr_rdy_c,
`ifdef SDINIT_HCS_EN
  output logic        ocr_ccs_c,
`endif
  output logic [15:0] rca_c
);

  logic [3:0]  vhs_q;
  logic [7:0]  pat_q;
  logic        ocr_rdy_q;
  logic [15:0] rca_q;

  logic hit_b1, hit_b2, hit_b3, hit_b4;

  assign hit_b1 = rsp_vld && (rsp_ptr == PTR_B1);
  assign hit_b2 = rsp_vld && (rsp_ptr == PTR_B2);
  assign hit_b3 = rsp_vld && (rsp_ptr == PTR_B3);
  assign hit_b4 = rsp_vld && (rsp_ptr == PTR_B4);

  // Next-value views let the FSM judge a byte arriving with cmd_done
  assign vhs_c     = (we_r7 && hit_b3)  ? rsp_byte[3:0] : vhs_q;
  assign pat_c     = (we_r7 && hit_b4)  ? rsp_byte      : pat_q;
  assign ocr_rdy_c = (we_ocr && hit_b1) ? rsp_byte[7]   : ocr_rdy_q;
  assign rca_c[15:8] = (we_rca && hit_b1) ? rsp_byte : rca_q[15:8];
  assign rca_c[7:0]  = (we_rca && hit_b2) ? rsp_byte : rca_q[7:0];

  always_ff @(negedge clk or posedge reset) begin
    if (reset) begin
      vhs_q     <= '0;
      pat_q     <= '0;
      ocr_rdy_q <= 1'b0;
      rca_q     <= '0;
    end else if (clr) begin
      vhs_q     <= '0;
      pat_q     <= '0;
      ocr_rdy_q <= 1'b0;
      rca_q     <= '0;
    end else begin
      vhs_q     <= vhs_c;
      pat_q     <= pat_c;
      ocr_rdy_q <= ocr_rdy_c;
      rca_q     <= rca_c;
    end
  end

`ifdef SDINIT_HCS_EN
  logic ocr_ccs_q;

  assign ocr_ccs_c = (we_ocr && hit_b1) ? rsp_byte[6] : ocr_ccs_q;

  always_ff @(negedge clk or posedge reset) begin
    if (reset) begin
      ocr_ccs_q <= 1'b0;
    end else if (clr) begin
      ocr_ccs_q <= 1'b0;
    end else begin
      ocr_ccs_q <= ocr_ccs_c;
    end
  end
`endif

endmodule

// File: rtl/sd_init_seq.sv
// SD-card native-mode initialization sequencer: CMD0, CMD8, CMD55/ACMD41 loop, CMD2, CMD3.
// SDINIT_HCS_EN enables the HCS request in ACMD41 and the ccs output.
module sd_init_seq
  import sdinit_pkg::*;
#(
  parameter int unsigned PWRUP_CYC  = 80,
  parameter int unsigned TOUT_W     = 16,
  parameter int unsigned ACMD41_MAX = 1000,
  parameter logic [3:0]  VHS        = 4'h1,
  parameter logic [7:0]  CHK_PAT    = 8'hAA
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic        cmd_start,
  output logic [5:0]  cmd_idx,
  output logic [31:0] cmd_arg,
  input  logic        cmd_done,
  input  logic        cmd_tout,
  input  logic        rsp_vld,
  input  logic [2:0]  rsp_ptr,
  input  logic [7:0]  rsp_byte,
  output logic        busy,
  output logic        init_done,
  output logic        init_err,
  output logic [2:0]  err_code,
  output logic [15:0] rca,
  output logic        ccs
);

  localparam int unsigned PWR_W = (PWRUP_CYC > 1) ? $clog2(PWRUP_CYC) : 1;
  localparam logic [PWR_W-1:0]  PWR_LAST  = PWR_W'(PWRUP_CYC - 1);
  localparam logic [TOUT_W-1:0] A41_LIMIT = TOUT_W'(ACMD41_MAX);
`ifdef SDINIT_HCS_EN
  localparam logic HCS = 1'b1;
`else
  localparam logic HCS = 1'b0;
`endif

  sd_state_e         state_q, state_d;
  logic [PWR_W-1:0]  pwr_cnt_q, pwr_cnt_d;
  logic [TOUT_W-1:0] a41_cnt_q, a41_cnt_d;
  logic [2:0]        err_q, err_d;
  logic [15:0]       rca_q, rca_d;
  sd_cmd_t           cmd_q, cmd_d;
  logic              cmd_start_d, busy_d, done_d, errf_d;
  logic              restart_c;

  logic              we_r7, we_ocr, we_rca;
  logic [3:0]        vhs_c;
  logic [7:0]        pat_c;
  logic              ocr_rdy_c;
  logic [15:0]       rca_c;
`ifdef SDINIT_HCS_EN
  logic              ocr_ccs_c;
`endif

  assign we_r7  = (state_q == ST_CMD8);
  assign we_ocr = (state_q == ST_ACMD41);
  assign we_rca = (state_q == ST_CMD3);

  sd_rsp_capt u_capt (
    .clk       (clk),
    .reset     (reset),
    .clr       (restart_c),
    .rsp_vld   (rsp_vld),
    .rsp_ptr   (rsp_ptr),
    .rsp_byte  (rsp_byte),
    .we_r7     (we_r7),
    .we_ocr    (we_ocr),
    .we_rca    (we_rca),
    .vhs_c     (vhs_c),
    .pat_c     (pat_c),
    .ocr_rdy_c (ocr_rdy_c),
`ifdef SDINIT_HCS_EN
    .ocr_ccs_c (ocr_ccs_c),
`endif
    .rca_c     (rca_c)
  );

  // Next state, counters, status and registered-output precompute
  always_comb begin
    state_d   = state_q;
    pwr_cnt_d = pwr_cnt_q;
    a41_cnt_d = a41_cnt_q;
    err_d     = err_q;
    rca_d     = rca_q;
    restart_c = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_PWRUP;
      end
      ST_PWRUP: begin
        if (pwr_cnt_q == PWR_LAST) begin
          state_d   = ST_CMD0;
          pwr_cnt_d = '0;
        end else begin
          pwr_cnt_d = pwr_cnt_q + PWR_W'(1);
        end
      end
      ST_CMD0: begin
        // CMD0 has no response, so a timeout here is normal
        if (cmd_done) state_d = ST_CMD8;
      end
      ST_CMD8: begin
        if (cmd_done) begin
          if (cmd_tout) begin
            state_d = ST_ERR;
            err_d   = ERR_NORSP;
          end else if ((vhs_c != VHS) || (pat_c != CHK_PAT)) begin
            state_d = ST_ERR;
            err_d   = ERR_ECHO;
          end else begin
            state_d = ST_CMD55;
          end
        end
      end
      ST_CMD55: begin
        if (cmd_done) begin
          if (cmd_tout) begin
            state_d = ST_ERR;
            err_d   = ERR_NORSP;
          end else begin
            state_d = ST_ACMD41;
          end
        end
      end
      ST_ACMD41: begin
        if (cmd_done) begin
          if (cmd_tout) begin
            state_d = ST_ERR;
            err_d   = ERR_NORSP;
          end else if (ocr_rdy_c) begin
            state_d = ST_CMD2;
          end else begin
            a41_cnt_d = (a41_cnt_q == '1) ? a41_cnt_q : a41_cnt_q + TOUT_W'(1);
            if (a41_cnt_d >= A41_LIMIT) begin
              state_d = ST_ERR;
              err_d   = ERR_A41TO;
            end else begin
              state_d = ST_CMD55;
            end
          end
        end
      end
      ST_CMD2: begin
        if (cmd_done) begin
          if (cmd_tout) begin
            state_d = ST_ERR;
            err_d   = ERR_NORSP;
          end else begin
            state_d = ST_CMD3;
          end
        end
      end
      ST_CMD3: begin
        if (cmd_done) begin
          if (cmd_tout) begin
            state_d = ST_ERR;
            err_d   = ERR_NORSP;
          end else begin
            state_d = ST_DONE;
            rca_d   = rca_c;
          end
        end
      end
      ST_DONE, ST_ERR: begin
        if (start) begin
          restart_c = 1'b1;
          state_d   = ST_PWRUP;
          pwr_cnt_d = '0;
          a41_cnt_d = '0;
          err_d     = ERR_NONE;
          rca_d     = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    cmd_start_d = (state_d != state_q) && is_cmd_state(state_d);
    cmd_d       = cmd_start_d ? cmd_for_state(state_d, rca_q, HCS, VHS, CHK_PAT) : cmd_q;
    busy_d      = !((state_d == ST_IDLE) || (state_d == ST_DONE) || (state_d == ST_ERR));
    done_d      = (state_d == ST_DONE);
    errf_d      = (state_d == ST_ERR);
  end

  always_ff @(negedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      pwr_cnt_q <= '0;
      a41_cnt_q <= '0;
      err_q     <= ERR_NONE;
      rca_q     <= '0;
      cmd_q     <= '0;
      cmd_start <= 1'b0;
      busy      <= 1'b0;
      init_done <= 1'b0;
      init_err  <= 1'b0;
    end else begin
      state_q   <= state_d;
      pwr_cnt_q <= pwr_cnt_d;
      a41_cnt_q <= a41_cnt_d;
      err_q     <= err_d;
      rca_q     <= rca_d;
      cmd_q     <= cmd_d;
      cmd_start <= cmd_start_d;
      busy      <= busy_d;
      init_done <= done_d;
      init_err  <= errf_d;
    end
  end

  assign cmd_idx  = cmd_q.idx;
  assign cmd_arg  = cmd_q.arg;
  assign err_code = err_q;
  assign rca      = rca_q;

`ifdef SDINIT_HCS_EN
  logic ccs_q;

  // Card capacity status is taken only from the response that reports ready
  always_ff @(negedge clk or posedge reset) begin
    if (reset) begin
      ccs_q <= 1'b0;
    end else if (restart_c) begin
      ccs_q <= 1'b0;
    end else if ((state_q == ST_ACMD41) && cmd_done && !cmd_tout && ocr_rdy_c) begin
      ccs_q <= ocr_ccs_c;
    end
  end

  assign ccs = ccs_q;
`else
  assign ccs = 1'b0;
`endif

endmodule
